// File: rtl/sevseg_anim_ctrl.sv
// Frame sequencer for a 7-segment spinner animation: steps a 3-bit frame index
// at a programmable rate in CW, CCW, ping-pong or one-shot order.
module sevseg_anim_ctrl #(
    parameter int PRESC_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_pause,
    input  logic [1:0]         i_mode,
    input  logic [PRESC_W-1:0] i_period,
    output logic [2:0]         o_count,
    output logic               o_step,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_blank
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;
    localparam logic [1:0] M_CCW = 2'b01, M_PP = 2'b10, M_ONE = 2'b11;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [2:0]         count_q, count_d, adv_count;
    logic [1:0]         mode_q, mode_d;
    logic               dir_q, dir_d, adv_dir;
    logic               step_q, step_d, done_q, done_d;
    logic               busy_q, busy_d, blank_q, blank_d;
    logic               expire;

    // >= rather than == so a live drop of i_period below the count steps at once
    assign expire = (presc_q >= i_period);

    always_comb begin
        adv_count = count_q + 3'd1;
        adv_dir   = dir_q;
        case (mode_q)
            M_CCW: adv_count = count_q - 3'd1;
            M_PP: begin
                if (dir_q) begin
                    adv_count = count_q + 3'd1;
                    if (count_q == 3'd6) adv_dir = 1'b0;
                end else begin
                    adv_count = count_q - 3'd1;
                    if (count_q == 3'd1) adv_dir = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        if (i_stop) begin
            state_d = IDLE;
            presc_d = '0;
            count_d = 3'd0;
            dir_d   = 1'b1;
        end else if (i_start) begin
            state_d = RUN;
            mode_d  = i_mode;
            presc_d = '0;
            count_d = 3'd0;
            dir_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    count_d = 3'd0;
                end
                DONE: begin
                    state_d = IDLE;
                    count_d = 3'd0;
                end
                default: begin
                    // A paused block that sees i_pause drop ticks on the same edge,
                    // so the delay equals exactly the number of paused cycles.
                    if (i_pause && !(state_q == RUN && expire)) begin
                        state_d = PAUSE;
                    end else if (!expire) begin
                        presc_d = presc_q + 1'b1;
                        state_d = RUN;
                    end else begin
                        presc_d = '0;
                        if (mode_q == M_ONE && count_q == 3'd7) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            count_d = adv_count;
                            dir_d   = adv_dir;
                            step_d  = 1'b1;
                            state_d = i_pause ? PAUSE : RUN;
                        end
                    end
                end
            endcase
        end
        busy_d  = (state_d == RUN) || (state_d == PAUSE);
        blank_d = (state_d == IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            count_q <= 3'd0;
            mode_q  <= 2'b00;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            blank_q <= blank_d;
        end
    end

    assign o_count = count_q;
    assign o_step  = step_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_blank = blank_q;
endmodule

// File: doc/sevseg_anim_ctrl.md
SEVSEG_ANIM_CTRL -- requirements
Module: sevseg_anim_ctrl

Interface
REQ-001 The block SHALL have parameter PRESC_W, default 16, the width of the step-period prescaler.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_start, input, 1 bit: start or restart pulse.
REQ-005 The block SHALL have port i_stop, input, 1 bit: abort pulse.
REQ-006 The block SHALL have port i_pause, input, 1 bit: level-sensitive hold.
REQ-007 The block SHALL have port i_mode, input, 2 bits: 00 = CW loop, 01 = CCW loop, 10 = ping-pong, 11 = one-shot CW lap.
REQ-008 The block SHALL have port i_period, input, PRESC_W bits: one step every i_period+1 clocks.
REQ-009 The block SHALL have port o_count, output, 3 bits: frame index to the 7-segment pattern decoder.
REQ-010 The block SHALL have port o_step, output, 1 bit: one-cycle pulse, high in the cycle o_count takes a new value.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high in RUN and PAUSE.
REQ-012 The block SHALL have port o_done, output, 1 bit: one-cycle pulse at the end of a one-shot lap.
REQ-013 The block SHALL have port o_blank, output, 1 bit: display-blank request, high in IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE and DONE.
REQ-015 All outputs SHALL be registered.
REQ-016 Command priority SHALL be i_stop > i_start > i_pause.
REQ-017 IDLE: o_count=0, prescaler=0, o_blank=1; i_start SHALL transition to RUN.
REQ-018 i_start (from any state) SHALL latch i_mode, clear the prescaler, set o_count=0, set direction=up, and enter RUN.
REQ-019 RUN: the prescaler SHALL increment each cycle; when prescaler==i_period, it SHALL clear to 0, o_count SHALL advance one step and o_step SHALL pulse.
REQ-020 The first step after start SHALL occur i_period+1 cycles after the start edge.
REQ-021 i_period SHALL be sampled live on every cycle; if i_period is lowered below the current prescaler value, the block SHALL step on the next cycle and clear the prescaler, and SHALL NOT wrap around the prescaler.
REQ-022 i_period=0 SHALL produce a step every cycle.
REQ-023 CW mode: 0,1,...,7,0,... with modulo-8 wrap.
REQ-024 CCW mode: 0,7,6,...,1,0,... with modulo-8 wrap.
REQ-025 Ping-pong mode: 0..7,6..0,1..; direction SHALL flip on the step that reaches 7 or 0, so no index repeats.
REQ-026 One-shot mode: 0..7; on the step expiring at count 7, the FSM SHALL enter DONE (count held at 7, no o_step).
REQ-027 DONE SHALL last exactly one cycle with o_done=1, then enter IDLE.
REQ-028 RUN with i_pause=1 SHALL enter PAUSE on the next edge; prescaler and o_count SHALL freeze.
REQ-029 PAUSE with i_pause=0 SHALL return to RUN, and counting SHALL resume from the frozen prescaler value.
REQ-030 i_stop in RUN, PAUSE or DONE SHALL enter IDLE on the next edge, with o_count=0 and no o_done.
REQ-031 i_stop and i_start asserted together SHALL result in IDLE.
REQ-032 i_start in PAUSE SHALL restart into RUN, ignoring i_pause for that cycle.
REQ-033 A pause request coinciding with a step SHALL complete the step first, then freeze.
REQ-034 o_step, o_done and o_blank SHALL be mutually consistent: o_step=0 whenever o_blank=1.

Reset
REQ-035 i_rst_n=0 SHALL asynchronously force state=IDLE, o_count=0, prescaler=0, direction=up, o_step=0, o_done=0, o_busy=0, o_blank=1.
REQ-036 Deassertion of i_rst_n SHALL be synchronous to i_clk; the first command SHALL be accepted on the first edge after deassertion.
REQ-037 Reset mid-RUN SHALL discard the latched mode.

Verification
REQ-038 CW: mode=00, period=3, start -> o_step every 4 cycles; o_count 1,2,...,7,0,1; o_busy=1, o_blank=0.
REQ-039 Ping-pong: mode=10, period=0 -> o_count 1..7,6..0,1 on consecutive cycles; no value repeated at the ends.
REQ-040 One-shot: mode=11, period=1 -> 7 steps, then at cycle 16 DONE (o_done=1 for 1 cycle, o_count=7), then IDLE with o_count=0 and o_blank=1.
REQ-041 Pause: hold i_pause for 10 cycles mid-period -> o_count and prescaler frozen; the resumed step lands exactly 10 cycles late; CCW sequence intact.
REQ-042 Priority: i_stop with i_start together -> IDLE; i_start in PAUSE -> RUN with o_count=0; i_rst_n pulse mid-RUN -> immediate IDLE values without waiting for a clock edge.
